// File: rtl/mem_arb.sv
// mem_arb: two-port round-robin arbiter in front of a single-port synchronous RAM.
//
// The fetch port (if_*) and the load/store port (d_*) compete for one RAM.
// At most one request is granted per cycle. The winner drives the RAM in the
// same cycle. Read data returns to the owner RD_LAT cycles later through a
// {valid, owner} tag pipeline. A saturating counter records the number of
// cycles in which both ports requested at once.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch read request
//   if_gnt/if_rvalid/if_rdata      fetch grant, read-data valid, read data
//   d_req/d_we/d_addr/d_wdata      load/store request
//   d_gnt/d_rvalid/d_rdata         load/store grant, load-data valid, load data
//   m_en/m_we/m_addr/m_wdata       RAM command
//   m_rdata                        RAM read data, valid RD_LAT cycles after a read
//   conflict_cnt                   saturating count of cycles with both reqs high
module mem_arb #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1  // legal 1..4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,

    output logic [15:0]       conflict_cnt
);

    // 1 = data port was granted most recently; on a conflict the other port wins.
    logic              last_d_q, last_d_d;
    // Read-return tag pipeline: stage 0 is loaded in the grant cycle, the
    // last stage marks the cycle the RAM data is valid. owner 1 = data port.
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] own_q, own_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              conflict;
    logic              issue_rd;

    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        conflict = if_req && d_req;

        // Fetch wins when alone, or on a conflict if data won last time.
        if_gnt = if_req && (!d_req || last_d_q);
        d_gnt  = d_req && !if_gnt;

        m_en    = if_gnt || d_gnt;
        m_we    = d_gnt && d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (if_gnt) begin
            m_addr = if_addr;
        end else if (d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end

        issue_rd = m_en && !m_we;

        last_d_d = last_d_q;
        if (m_en) begin
            last_d_d = d_gnt;
        end

        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = issue_rd;
        own_d[0] = d_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end

        cnt_d = cnt_q;
        if (conflict && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b1;
            // NOTE: the owner tags are reset together with the valids even though
            // they are only looked at when valid; it keeps the outputs free of X.
            vld_q    <= '0;
            own_q    <= '0;
            cnt_q    <= '0;
        end else begin
            last_d_q <= last_d_d;
            vld_q    <= vld_d;
            own_q    <= own_d;
            cnt_q    <= cnt_d;
        end
    end

    assign if_rvalid    = vld_q[RD_LAT-1] && !own_q[RD_LAT-1];
    assign d_rvalid     = vld_q[RD_LAT-1] &&  own_q[RD_LAT-1];
    assign if_rdata     = m_rdata;
    assign d_rdata      = m_rdata;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb.
//
// Two instances share one stimulus stream: one with RD_LAT=1 and one with
// RD_LAT=3, each with its own behavioural RAM. A transaction-level model
// (last-granted port, reference memory, queue of expected returns tagged with
// their due cycle) predicts every output. Directed table vectors cover the
// named scenarios; hand sequences cover mid-operation reset and counter
// saturation; a random phase covers the rest.
module tb_mem_arb;

    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, m_en_1, m_we_1;
    logic [AW-1:0] m_addr_1;
    logic [DW-1:0] if_rdata_1, d_rdata_1, m_wdata_1, m_rdata_1;
    logic [15:0]   cnt_1;

    logic          if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, m_en_3, m_we_3;
    logic [AW-1:0] m_addr_3;
    logic [DW-1:0] if_rdata_3, d_rdata_3, m_wdata_3, m_rdata_3;
    logic [15:0]   cnt_3;

    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
        .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .m_en(m_en_1), .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1),
        .m_rdata(m_rdata_1), .conflict_cnt(cnt_1)
    );

    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
        .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .m_en(m_en_3), .m_we(m_we_3), .m_addr(m_addr_3), .m_wdata(m_wdata_3),
        .m_rdata(m_rdata_3), .conflict_cnt(cnt_3)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 0) ? 32'h0000_0013 : (32'hA500_0000 | 32'(a));
    endfunction

    // Behavioural RAMs: contents reload while rst is high; read data appears
    // RD_LAT cycles after the read command.
    logic [DW-1:0] ram_1 [64];
    logic [DW-1:0] ram_3 [64];
    logic [DW-1:0] dl_1;
    logic [DW-1:0] dl_3 [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram_1[i[5:0]] <= init_val(i);
        end else if (m_en_1 && m_we_1) begin
            ram_1[m_addr_1] <= m_wdata_1;
        end
        dl_1 <= (m_en_1 && !m_we_1) ? ram_1[m_addr_1] : '0;
    end
    assign m_rdata_1 = dl_1;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram_3[i[5:0]] <= init_val(i);
        end else if (m_en_3 && m_we_3) begin
            ram_3[m_addr_3] <= m_wdata_3;
        end
        dl_3[0] <= (m_en_3 && !m_we_3) ? ram_3[m_addr_3] : '0;
        dl_3[1] <= dl_3[0];
        dl_3[2] <= dl_3[1];
    end
    assign m_rdata_3 = dl_3[2];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;   // model cycle in which the data must come back
        int            li;    // 0 = RD_LAT 1 instance, 1 = RD_LAT 3 instance
        bit            port;  // 1 = data port
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] ref_mem [64];
    bit            mdl_last_d;
    int            mdl_cnt;
    bit            mdl_ig, mdl_dg;
    int            cyc = 0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_inst(input string tag, input int li,
                              input logic ig, input logic dg, input logic men, input logic mwe,
                              input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                              input logic iv, input logic dv,
                              input logic [DW-1:0] ird, input logic [DW-1:0] drd,
                              input logic [15:0] cnt);
        bit            exp_iv, exp_dv, exp_we;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_addr;
        exp_iv   = 1'b0;
        exp_dv   = 1'b0;
        exp_data = '0;
        foreach (rq[k]) begin
            if (rq[k].li == li && rq[k].due == cyc) begin
                if (rq[k].port) exp_dv = 1'b1;
                else            exp_iv = 1'b1;
                exp_data = rq[k].data;
            end
        end
        exp_we   = mdl_dg && d_we;
        exp_addr = mdl_ig ? if_addr : (mdl_dg ? d_addr : '0);
        check({tag, ".if_gnt"}, 64'(ig), 64'(mdl_ig));
        check({tag, ".d_gnt"}, 64'(dg), 64'(mdl_dg));
        check({tag, ".m_en"}, 64'(men), 64'(mdl_ig || mdl_dg));
        check({tag, ".m_we"}, 64'(mwe), 64'(exp_we));
        check({tag, ".m_addr"}, 64'(ma), 64'(exp_addr));
        if (exp_we) check({tag, ".m_wdata"}, 64'(mwd), 64'(d_wdata));
        else if (!(mdl_ig || mdl_dg)) check({tag, ".m_wdata_idle"}, 64'(mwd), 64'(0));
        check({tag, ".if_rvalid"}, 64'(iv), 64'(exp_iv));
        check({tag, ".d_rvalid"}, 64'(dv), 64'(exp_dv));
        if (exp_iv) check({tag, ".if_rdata"}, 64'(ird), 64'(exp_data));
        if (exp_dv) check({tag, ".d_rdata"}, 64'(drd), 64'(exp_data));
        check({tag, ".conflict_cnt"}, 64'(cnt), 64'(mdl_cnt));
    endtask

    // Called at the falling edge with inputs stable: compare, then advance the
    // model across the coming rising edge.
    task automatic check_cycle();
        ret_t          keep[$];
        logic [DW-1:0] rdv;
        mdl_ig = if_req && (!d_req || mdl_last_d);
        mdl_dg = d_req && !mdl_ig;
        check_inst("L1", 0, if_gnt_1, d_gnt_1, m_en_1, m_we_1, m_addr_1, m_wdata_1,
                   if_rvalid_1, d_rvalid_1, if_rdata_1, d_rdata_1, cnt_1);
        check_inst("L3", 1, if_gnt_3, d_gnt_3, m_en_3, m_we_3, m_addr_3, m_wdata_3,
                   if_rvalid_3, d_rvalid_3, if_rdata_3, d_rdata_3, cnt_3);
        foreach (rq[k]) if (rq[k].due > cyc) keep.push_back(rq[k]);
        rq = keep;
        if (mdl_ig || mdl_dg) mdl_last_d = mdl_dg;
        if (mdl_dg && d_we) begin
            ref_mem[d_addr] = d_wdata;
        end else if (mdl_ig || mdl_dg) begin
            rdv = ref_mem[mdl_ig ? if_addr : d_addr];
            rq.push_back('{cyc + 1, 0, mdl_dg, rdv});
            rq.push_back('{cyc + 3, 1, mdl_dg, rdv});
        end
        if (if_req && d_req && mdl_cnt < 65535) mdl_cnt++;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset right away (asynchronously), checks the reset state and
    // releases it shortly after a rising edge.
    task automatic do_reset();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        rst    = 1'b1;
        rq.delete();
        mdl_last_d = 1'b1;
        mdl_cnt    = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        @(negedge clk);
        check("rst.m_en", 64'({m_en_1, m_en_3}), 64'(0));
        check("rst.m_we", 64'({m_we_1, m_we_3}), 64'(0));
        check("rst.rvalid", 64'({if_rvalid_1, d_rvalid_1, if_rvalid_3, d_rvalid_3}), 64'(0));
        check("rst.cnt", 64'({cnt_1, cnt_3}), 64'(0));
        check("rst.rdata_pass", 64'({if_rdata_3, d_rdata_3}), 64'({m_rdata_3, m_rdata_3}));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit            rst_b;
        bit            ir;
        logic [AW-1:0] ia;
        bit            dr;
        bit            dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        bit            e_ig;
        bit            e_dg;
        bit            e_we;
        int            e_cnt;
        bit            chk1;
        logic [1:0]    e_rv1;  // {d_rvalid, if_rvalid} of the RD_LAT 1 instance
        logic [DW-1:0] e_rd1;
        bit            chk3;
        logic [1:0]    e_rv3;  // {d_rvalid, if_rvalid} of the RD_LAT 3 instance
        logic [DW-1:0] e_rd3;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // fetch read of address 0, then store/load of address 5
        tbl[0]  = '{1, 1, 6'h00, 0, 0, 6'h00, 32'h0,        1, 0, 0, 0, 1, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[1]  = '{0, 0, 6'h00, 1, 1, 6'h05, 32'hDEADBEEF, 0, 1, 1, 0, 1, 2'b01, 32'h0000_0013, 0, 2'b00, 32'h0};
        tbl[2]  = '{0, 0, 6'h00, 1, 0, 6'h05, 32'h0,        0, 1, 0, 0, 1, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[3]  = '{0, 0, 6'h00, 0, 0, 6'h00, 32'h0,        0, 0, 0, 0, 1, 2'b10, 32'hDEADBEEF,  0, 2'b00, 32'h0};
        // six conflict cycles from reset: IF,D,IF,D,IF,D
        tbl[4]  = '{1, 1, 6'h01, 1, 0, 6'h02, 32'h0,        1, 0, 0, 0, 1, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[5]  = '{0, 1, 6'h01, 1, 0, 6'h02, 32'h0,        0, 1, 0, 1, 0, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[6]  = '{0, 1, 6'h01, 1, 0, 6'h02, 32'h0,        1, 0, 0, 2, 0, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[7]  = '{0, 1, 6'h01, 1, 0, 6'h02, 32'h0,        0, 1, 0, 3, 0, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[8]  = '{0, 1, 6'h01, 1, 0, 6'h02, 32'h0,        1, 0, 0, 4, 0, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[9]  = '{0, 1, 6'h01, 1, 0, 6'h02, 32'h0,        0, 1, 0, 5, 0, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        tbl[10] = '{0, 0, 6'h00, 0, 0, 6'h00, 32'h0,        0, 0, 0, 6, 0, 2'b00, 32'h0,         0, 2'b00, 32'h0};
        // back-to-back fetches at 1,2,3; RD_LAT 3 returns three cycles later
        tbl[11] = '{1, 1, 6'h01, 0, 0, 6'h00, 32'h0,        1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b00, 32'h0};
        tbl[12] = '{0, 1, 6'h02, 0, 0, 6'h00, 32'h0,        1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b00, 32'h0};
        tbl[13] = '{0, 1, 6'h03, 0, 0, 6'h00, 32'h0,        1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b00, 32'h0};
        tbl[14] = '{0, 0, 6'h00, 0, 0, 6'h00, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b01, 32'hA500_0001};
        tbl[15] = '{0, 0, 6'h00, 0, 0, 6'h00, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b01, 32'hA500_0002};
        tbl[16] = '{0, 0, 6'h00, 0, 0, 6'h00, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b01, 32'hA500_0003};
        tbl[17] = '{0, 0, 6'h00, 0, 0, 6'h00, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0,         1, 2'b00, 32'h0};

        do_reset();

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst_b) do_reset();
            if_req  = tbl[i].ir;
            if_addr = tbl[i].ia;
            d_req   = tbl[i].dr;
            d_we    = tbl[i].dw;
            d_addr  = tbl[i].da;
            d_wdata = tbl[i].dd;
            @(negedge clk);
            check($sformatf("tbl%0d.if_gnt", i), 64'({if_gnt_1, if_gnt_3}), 64'({tbl[i].e_ig, tbl[i].e_ig}));
            check($sformatf("tbl%0d.d_gnt", i), 64'({d_gnt_1, d_gnt_3}), 64'({tbl[i].e_dg, tbl[i].e_dg}));
            check($sformatf("tbl%0d.m_we", i), 64'(m_we_1), 64'(tbl[i].e_we));
            check($sformatf("tbl%0d.cnt", i), 64'({cnt_1, cnt_3}), 64'({16'(tbl[i].e_cnt), 16'(tbl[i].e_cnt)}));
            if (tbl[i].chk1) begin
                check($sformatf("tbl%0d.rv1", i), 64'({d_rvalid_1, if_rvalid_1}), 64'(tbl[i].e_rv1));
                if (tbl[i].e_rv1[0]) check($sformatf("tbl%0d.if_rdata1", i), 64'(if_rdata_1), 64'(tbl[i].e_rd1));
                if (tbl[i].e_rv1[1]) check($sformatf("tbl%0d.d_rdata1", i), 64'(d_rdata_1), 64'(tbl[i].e_rd1));
            end
            if (tbl[i].chk3) begin
                check($sformatf("tbl%0d.rv3", i), 64'({d_rvalid_3, if_rvalid_3}), 64'(tbl[i].e_rv3));
                if (tbl[i].e_rv3[0]) check($sformatf("tbl%0d.if_rdata3", i), 64'(if_rdata_3), 64'(tbl[i].e_rd3));
            end
            check_cycle();
            @(posedge clk);
            #1;
        end

        // ---------------- reset while a read is in flight ----------------
        do_reset();
        if_req  = 1'b1;
        if_addr = 6'h02;
        step();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        if_req  = 1'b1;
        if_addr = 6'h04;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 6'h06;
        @(negedge clk);
        check("rstmid.cnt", 64'({cnt_1, cnt_3}), 64'(0));
        check("rstmid.fetch_wins", 64'({if_gnt_3, d_gnt_3}), 64'(2'b10));
        check_cycle();
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // ---------------- random traffic ----------------
        for (int c = 0; c < 600; c++) begin
            if (!if_req || mdl_ig) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 6'($urandom_range(0, 7));
            end else if ($urandom_range(0, 9) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req || mdl_dg) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 6'($urandom_range(0, 7));
                d_wdata = $urandom();
            end else if ($urandom_range(0, 9) == 0) begin
                d_req = 1'b0;
            end
            step();
        end

        // ---------------- conflict counter saturation ----------------
        do_reset();
        if_req  = 1'b1;
        if_addr = 6'h01;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 6'h02;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat.before", 64'({cnt_1, cnt_3}), 64'({16'hFFFE, 16'hFFFE}));
        @(posedge clk);
        @(negedge clk);
        check("sat.reach", 64'({cnt_1, cnt_3}), 64'({16'hFFFF, 16'hFFFF}));
        repeat (4500) @(posedge clk);
        @(negedge clk);
        check("sat.hold", 64'({cnt_1, cnt_3}), 64'({16'hFFFF, 16'hFFFF}));
        if_req = 1'b0;
        d_req  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
